regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side initiator for the 16-entry, 32-bit CPU register file. It merges ALU results and load-unit results into the single register-file write port. Loads are buffered in a small in-order FIFO; ALU results take priority. Forwarding outputs expose in-flight write data to the operand-read stage. Its registered outputs drive the register file's RegW, DR and Reg_in inputs directly.

## Interface
- DEPTH, 4, load FIFO entries; power of 2, at least 2
- AW, 4, register address width
- DW, 32, data width
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  reset; synchronous, active-high
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_dr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load accepted when ld_valid && ld_ready at the edge
- ld_dr  in  AW  load destination register
- ld_data  in  DW  load data
- RegW  out  1  register-file write enable (registered)
- DR  out  AW  register-file write address (registered)
- Reg_in  out  DW  register-file write data (registered)
- SR1, SR2  in  AW  operand addresses being read this cycle
- hit1, hit2  out  1  an in-flight write targets SR1 / SR2 (combinational)
- fwd1, fwd2  out  DW  data of the youngest in-flight write to SR1 / SR2; 0 when no hit
- count  out  $clog2(DEPTH)+1  live FIFO occupancy, including killed entries
- full  out  1  count == DEPTH

## Operation
- FIFO entry fields: dr, data, live bit. Head pointer, tail pointer, count; pointers wrap modulo DEPTH.
- ld_ready = !full && !RESET. A load is never pushed when full. Push and pop in the same cycle is legal whenever not full.
- Issue priority at each edge, highest first:
  - alu_valid: output stage loads {1, alu_dr, alu_data}.
  - Else, if the FIFO is not empty: pop the head.
    - Live head: output stage loads {1, head.dr, head.data}.
    - Killed head: entry is dropped; output stage loads RegW=0, and DR/Reg_in hold their values.
  - Else: RegW=0; DR/Reg_in hold.
- Kill rule: when alu_valid, every FIFO entry already stored with dr == alu_dr has its live bit cleared at that edge. This stops an older load from overwriting a newer ALU result.
- Same-cycle rule: a load accepted in the same cycle as alu_valid with the same dr is treated as younger and is not killed. The load's value ends up in the register.
- Forwarding for SR1 (SR2 is identical):
  - First priority: the youngest live FIFO entry with dr == SR1.
  - Otherwise: the output stage, if RegW && DR == SR1.
  - Otherwise: hit1=0 and fwd1=0.
  - Killed entries never hit. Inputs arriving in the current cycle (alu_*, ld_*) are not forwarded.
- Register 0 has no special treatment.

## Timing
- Reset values: RegW=0, DR=0, Reg_in=0, count=0, full=0, every live bit=0, pointers=0. ld_ready=0 while RESET is high. hit1/hit2 and fwd1/fwd2 are 0 after reset.
- Reset mid-operation: all queued loads are discarded, and an in-flight RegW is cleared at the reset edge. No write reaches the register file after that edge.
- ALU latency:
  - ALU result sampled at edge k → RegW/DR/Reg_in valid in cycle k+1.
  - The register file commits it at edge k+1.
- Load latency:
  - Minimum: accepted at edge k → popped at edge k+1 (if alu_valid=0) → RegW high in cycle k+1+1.
  - Each ALU cycle delays the head by one cycle.
  - There is no empty-FIFO bypass.
- Throughput: at most one register-file write per cycle. Sustained ALU traffic starves loads. The FIFO then fills, and ld_ready drops in the cycle after count reaches DEPTH.
- When full, ld_ready=0 even if a pop occurs in the same cycle. ld_ready rises the cycle after count < DEPTH.

## Test plan
- Reset then idle → RegW=0, DR=0, Reg_in=0, count=0, ld_ready=1 after RESET deasserts. Assert RESET with 3 loads queued → count=0 and RegW=0 the next cycle, and no write appears afterwards.
- ALU only: alu_dr=5, alu_data=0xDEADBEEF at edge k → RegW=1, DR=5, Reg_in=0xDEADBEEF in cycle k+1, then RegW=0. Load only: ld_dr=3, ld_data=0x11 accepted at edge k → RegW=1, DR=3 in cycle k+2.
- Priority and back-pressure:
  - Hold alu_valid=1 for 6 cycles while offering loads every cycle with DEPTH=4.
  - Required: exactly 4 loads accepted; ld_ready=0 once full.
  - After alu_valid drops: loads issue in acceptance order, one per cycle.
- Kill:
  - Queue a load to r7=0xAAAA, then issue an ALU write to r7=0xBBBB.
  - Required: a single RegW for r7 with 0xBBBB, and one bubble cycle (RegW=0) when the killed head pops.
  - Same-cycle case: load r7=0xCCCC and ALU r7=0xDDDD in one cycle → writes 0xDDDD then 0xCCCC.
- Forwarding:
  - Queue loads r2=0x1 then r2=0x2 → hit1=1, fwd1=0x2 with SR1=2.
  - With the output stage holding r9=0x55 → hit2=1, fwd2=0x55 with SR2=9.
  - SR1=4 with nothing in flight → hit1=0, fwd1=0.
- Wrap-around: push/pop 3×DEPTH loads with interleaved ALU writes to distinct registers → every write appears exactly once, in order. count never exceeds DEPTH.

Source files
------------

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Write-side initiator for the 16-entry, 32-bit CPU register file. ALU results
// and load-unit results share the single register-file write port. ALU results
// always win the port. Loads wait in a small in-order FIFO and drain when the
// ALU is idle. The registered outputs RegW/DR/Reg_in connect directly to the
// register file's write port.
//
// Ports
//   CLK, RESET               clock; synchronous active-high reset
//   alu_valid/alu_dr/alu_data ALU result; no backpressure
//   ld_valid/ld_ready/ld_dr/ld_data
//                            load result handshake
//   RegW, DR, Reg_in         registered register-file write port
//   SR1, SR2                 operand addresses read this cycle
//   hit1/fwd1, hit2/fwd2     forwarding of the youngest in-flight write to
//                            SR1 / SR2; fwd is 0 when there is no hit
//   count, full              FIFO occupancy (killed entries included)
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,

    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_dr,
    input  logic [DW-1:0]            alu_data,

    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [AW-1:0]            ld_dr,
    input  logic [DW-1:0]            ld_data,

    output logic                     RegW,
    output logic [AW-1:0]            DR,
    output logic [DW-1:0]            Reg_in,

    input  logic [AW-1:0]            SR1,
    input  logic [AW-1:0]            SR2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage. The data fields carry no reset; only the live bits,
    // pointers and occupancy define which slots hold meaningful entries.
    logic [AW-1:0]    mem_dr   [DEPTH];
    logic [DW-1:0]    mem_data [DEPTH];
    logic [DEPTH-1:0] live;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;

    logic             push;
    logic             pop;

    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    // Depends only on registered occupancy, so a pop in the same cycle does
    // not reopen the FIFO until the following cycle.
    assign ld_ready = !full && !RESET;

    assign push = ld_valid && ld_ready;
    // The head only advances when the ALU leaves the write port free.
    assign pop  = !alu_valid && (cnt != '0);

    // -------------------------------------------------------------------------
    // Control state: pointers, occupancy, live bits, output stage
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            live   <= '0;
            RegW   <= 1'b0;
            DR     <= '0;
            Reg_in <= '0;
        end else begin
            if (pop) begin
                head       <= head + PW'(1);
                live[head] <= 1'b0;
            end

            // Kill older queued loads that the ALU result supersedes. A load
            // accepted at this same edge is written below and therefore
            // survives: it counts as the younger write.
            if (alu_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_dr[i] == alu_dr) begin
                        live[i] <= 1'b0;
                    end
                end
            end

            if (push) begin
                tail       <= tail + PW'(1);
                live[tail] <= 1'b1;
            end

            cnt <= cnt + CW'(push) - CW'(pop);

            // Output stage: ALU first, then a live FIFO head. A killed head
            // is dropped as a bubble; DR/Reg_in keep their last values.
            if (alu_valid) begin
                RegW   <= 1'b1;
                DR     <= alu_dr;
                Reg_in <= alu_data;
            end else if (pop && live[head]) begin
                RegW   <= 1'b1;
                DR     <= mem_dr[head];
                Reg_in <= mem_data[head];
            end else begin
                RegW   <= 1'b0;
            end
        end
    end

    // FIFO payload write; no write can occur during reset because ld_ready
    // is low then.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_dr[tail]   <= ld_dr;
            mem_data[tail] <= ld_data;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding: the output stage is the oldest in-flight write, then the
    // FIFO from head (oldest) to tail (youngest). Scanning in that order and
    // letting later matches overwrite earlier ones yields the youngest write.
    // -------------------------------------------------------------------------
    logic [AW-1:0] sr_sel [2];
    assign sr_sel[0] = SR1;
    assign sr_sel[1] = SR2;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic          hit_g;
        logic [DW-1:0] fwd_g;
        logic [PW-1:0] idx;

        always_comb begin
            hit_g = 1'b0;
            fwd_g = '0;
            idx   = '0;
            if (RegW && (DR == sr_sel[p])) begin
                hit_g = 1'b1;
                fwd_g = Reg_in;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + PW'(k);
                if ((CW'(k) < cnt) && live[idx] && (mem_dr[idx] == sr_sel[p])) begin
                    hit_g = 1'b1;
                    fwd_g = mem_data[idx];
                end
            end
        end
    end

    assign hit1 = g_fwd[0].hit_g;
    assign fwd1 = g_fwd[0].fwd_g;
    assign hit2 = g_fwd[1].hit_g;
    assign fwd2 = g_fwd[1].fwd_g;

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//
// Directed and random stimulus for regfile_writeback. A queue-based reference
// model tracks pending loads and the register-file write port; every cycle the
// DUT outputs are compared against it, plus directed literal checks.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          alu_valid;
    logic [AW-1:0] alu_dr;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_dr;
    logic [DW-1:0] ld_data;
    logic          RegW;
    logic [AW-1:0] DR;
    logic [DW-1:0] Reg_in;
    logic [AW-1:0] SR1;
    logic [AW-1:0] SR2;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic [$clog2(DEPTH):0] count;
    logic          full;

    regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .alu_valid(alu_valid),
        .alu_dr   (alu_dr),
        .alu_data (alu_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_dr    (ld_dr),
        .ld_data  (ld_data),
        .RegW     (RegW),
        .DR       (DR),
        .Reg_in   (Reg_in),
        .SR1      (SR1),
        .SR2      (SR2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count),
        .full     (full)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    typedef struct packed {
        logic [AW-1:0] dr;
        logic [DW-1:0] data;
        logic          live;
    } ent_t;

    ent_t          q[$];
    logic          m_regw  = 1'b0;
    logic [AW-1:0] m_dr    = '0;
    logic [DW-1:0] m_regin = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_fwd(input logic [AW-1:0] sr, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].live && q[i].dr == sr) begin
                h = 1'b1;
                d = q[i].data;
                break;
            end
        end
        if (!h && m_regw && m_dr == sr) begin
            h = 1'b1;
            d = m_regin;
        end
    endfunction

    task automatic check_all();
        logic          eh;
        logic [DW-1:0] ed;
        chk("RegW",     64'(RegW),   64'(m_regw));
        chk("DR",       64'(DR),     64'(m_dr));
        chk("Reg_in",   64'(Reg_in), 64'(m_regin));
        chk("count",    64'(count),  64'(q.size()));
        chk("full",     64'(full),   64'(q.size() == DEPTH));
        chk("ld_ready", 64'(ld_ready), 64'((q.size() < DEPTH) && !RESET));
        chk("count_bound", 64'(count <= DEPTH), 64'd1);
        exp_fwd(SR1, eh, ed);
        chk("hit1", 64'(hit1), 64'(eh));
        chk("fwd1", 64'(fwd1), 64'(ed));
        exp_fwd(SR2, eh, ed);
        chk("hit2", 64'(hit2), 64'(eh));
        chk("fwd2", 64'(fwd2), 64'(ed));
    endtask

    // Advance the model by one edge with the inputs currently driven, then
    // clock the DUT and compare just after the edge.
    task automatic tick();
        logic acc;
        ent_t h;
        if (RESET) begin
            q.delete();
            m_regw  = 1'b0;
            m_dr    = '0;
            m_regin = '0;
        end else begin
            acc = ld_valid && (q.size() < DEPTH);
            if (alu_valid) begin
                foreach (q[i]) if (q[i].dr == alu_dr) q[i].live = 1'b0;
                m_regw  = 1'b1;
                m_dr    = alu_dr;
                m_regin = alu_data;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                if (h.live) begin
                    m_regw  = 1'b1;
                    m_dr    = h.dr;
                    m_regin = h.data;
                end else begin
                    m_regw = 1'b0;
                end
            end else begin
                m_regw = 1'b0;
            end
            if (acc) q.push_back('{dr: ld_dr, data: ld_data, live: 1'b1});
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_dr    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_dr     = '0;
        ld_data   = '0;
    endtask

    initial begin
        int acc;
        int cyc;

        RESET = 1'b1;
        SR1   = '0;
        SR2   = '0;
        idle_inputs();

        // Reset and idle
        tick();
        tick();
        chk("rst_RegW",     64'(RegW),     64'd0);
        chk("rst_DR",       64'(DR),       64'd0);
        chk("rst_Reg_in",   64'(Reg_in),   64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        RESET = 1'b0;
        tick();
        chk("idle_ld_ready", 64'(ld_ready), 64'd1);
        chk("idle_RegW",     64'(RegW),     64'd0);

        // ALU only
        alu_valid = 1'b1; alu_dr = 4'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        chk("alu_RegW",   64'(RegW),   64'd1);
        chk("alu_DR",     64'(DR),     64'd5);
        chk("alu_Reg_in", 64'(Reg_in), 64'hDEADBEEF);
        tick();
        chk("alu_after_RegW", 64'(RegW), 64'd0);

        // Load only: two edges to the write port
        ld_valid = 1'b1; ld_dr = 4'd3; ld_data = 32'h11;
        tick();
        idle_inputs();
        chk("ld_k1_RegW", 64'(RegW), 64'd0);
        tick();
        chk("ld_k2_RegW",   64'(RegW),   64'd1);
        chk("ld_k2_DR",     64'(DR),     64'd3);
        chk("ld_k2_Reg_in", 64'(Reg_in), 64'h11);
        tick();

        // Priority and back-pressure
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_dr = AW'(c); alu_data = 32'h100 + c;
            ld_valid  = 1'b1; ld_dr  = AW'(8 + c); ld_data = 32'h200 + c;
            if (ld_ready) acc++;
            tick();
        end
        idle_inputs();
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_full", 64'(full), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_RegW", 64'(RegW),   64'd1);
            chk("drain_DR",   64'(DR),     64'(8 + i));
            chk("drain_data", 64'(Reg_in), 64'(32'h200 + i));
        end
        tick();
        chk("drain_end_RegW", 64'(RegW), 64'd0);

        // Kill: older load superseded by ALU write
        ld_valid = 1'b1; ld_dr = 4'd7; ld_data = 32'hAAAA;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_dr = 4'd7; alu_data = 32'hBBBB;
        tick();
        idle_inputs();
        chk("kill_RegW", 64'(RegW),   64'd1);
        chk("kill_data", 64'(Reg_in), 64'hBBBB);
        tick();
        chk("kill_bubble_RegW", 64'(RegW),   64'd0);
        chk("kill_bubble_DR",   64'(DR),     64'd7);
        chk("kill_bubble_data", 64'(Reg_in), 64'hBBBB);
        tick();

        // Same-cycle: the load is younger and lands last
        ld_valid  = 1'b1; ld_dr  = 4'd7; ld_data  = 32'hCCCC;
        alu_valid = 1'b1; alu_dr = 4'd7; alu_data = 32'hDDDD;
        tick();
        idle_inputs();
        chk("same_first",  64'(Reg_in), 64'hDDDD);
        tick();
        chk("same_second_RegW", 64'(RegW),   64'd1);
        chk("same_second",      64'(Reg_in), 64'hCCCC);
        tick();

        // Forwarding
        SR1 = 4'd2; SR2 = 4'd9;
        alu_valid = 1'b1; alu_dr = 4'd14; alu_data = 32'h0;
        ld_valid  = 1'b1; ld_dr  = 4'd2;  ld_data  = 32'h1;
        tick();
        alu_dr = 4'd9; alu_data = 32'h55;
        ld_dr  = 4'd2; ld_data  = 32'h2;
        tick();
        idle_inputs();
        chk("fwd_hit1", 64'(hit1), 64'd1);
        chk("fwd_fwd1", 64'(fwd1), 64'h2);
        chk("fwd_hit2", 64'(hit2), 64'd1);
        chk("fwd_fwd2", 64'(fwd2), 64'h55);
        for (int i = 0; i < 4; i++) tick();
        SR1 = 4'd4;
        tick();
        chk("nofwd_hit1", 64'(hit1), 64'd0);
        chk("nofwd_fwd1", 64'(fwd1), 64'd0);

        // Reset with loads queued
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dr = 4'd1; alu_data = 32'h300 + i;
            ld_valid  = 1'b1; ld_dr  = AW'(10 + i); ld_data = 32'h400 + i;
            tick();
        end
        idle_inputs();
        chk("pre_rst_count", 64'(count), 64'd3);
        RESET = 1'b1;
        tick();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_RegW",  64'(RegW),  64'd0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_RegW", 64'(RegW), 64'd0);
        end

        // Wrap-around: 3*DEPTH loads with interleaved ALU writes
        acc = 0;
        cyc = 0;
        while (acc < 3 * DEPTH && cyc < 200) begin
            alu_valid = (cyc % 2) == 0;
            alu_dr    = AW'(cyc % 8);
            alu_data  = 32'h500 + cyc;
            ld_valid  = 1'b1;
            ld_dr     = AW'(8 + (acc % 8));
            ld_data   = 32'h600 + acc;
            if (ld_ready) acc++;
            tick();
            cyc++;
        end
        chk("wrap_loads_done", 64'(acc), 64'(3 * DEPTH));
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) tick();
        chk("wrap_empty", 64'(count), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            RESET     = ($urandom_range(0, 99) == 0);
            alu_valid = $urandom_range(0, 2) == 0;
            alu_dr    = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
            ld_valid  = $urandom_range(0, 3) != 0;
            ld_dr     = AW'($urandom_range(0, 7));
            ld_data   = $urandom;
            SR1       = AW'($urandom_range(0, 8));
            SR2       = AW'($urandom_range(0, 8));
            tick();
        end
        RESET = 1'b0;
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
